acc_cfg_adder_pipe: RTL

//  Parametrised, pipelined accuracy-configurable adder (ACA) for the VLSI datapath. Splits operands into BLK-bit segments.

---
 rtl/acc_cfg_adder_pipe.sv | 112 +++++++++++
 1 files changed

// File: rtl/acc_cfg_adder_pipe.sv
// acc_cfg_adder_pipe: pipelined accuracy-configurable adder with per-segment carry speculation and error monitoring
module acc_cfg_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int BLK   = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     Sum,
  output logic                 Cout,
  output logic                 err,
  output logic [WIDTH/BLK-1:0] err_seg,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     err_cnt
);
  localparam int NSEG = WIDTH / BLK;
  logic                          w_en;
  logic                          r0_v, r0_m;
  logic [WIDTH-1:0]              r0_a, r0_b;
  logic [NSEG-1:0][BLK-1:0]      w_s0, w_s1;
  logic [NSEG-1:0]               w_g, w_p;
  logic                          r1_v, r1_m;
  logic [NSEG-1:0][BLK-1:0]      r1_s0, r1_s1;
  logic [NSEG-1:0]               r1_g, r1_p;
  logic [NSEG-1:0]               w_cs, w_ct;
  logic [WIDTH-1:0]              w_sa, w_se;
  logic                          w_ca, w_ce;
  logic                          r2_v, r2_m, r2_ca, r2_ce;
  logic [WIDTH-1:0]              r2_sa, r2_se;
  logic [NSEG-1:0]               r2_es;
  logic                          r_ov, r_cout, r_err;
  logic [WIDTH-1:0]              r_sum;
  logic [NSEG-1:0]               r_es;
  logic [CNT_W-1:0]              r_cnt;
  assign w_en      = out_ready | ~r_ov;
  assign in_ready  = w_en;
  assign out_valid = r_ov;
  assign Sum       = r_sum;
  assign Cout      = r_cout;
  assign err       = r_err;
  assign err_seg   = r_es;
  assign err_cnt   = r_cnt;
  // Per segment: sum for cin=0 and cin=1, generate (cout at cin=0) and propagate
  always_comb begin
    w_s0 = '0;
    w_s1 = '0;
    w_g  = '0;
    w_p  = '0;
    for (int k = 0; k < NSEG; k++) begin
      {w_g[k], w_s0[k]} = {1'b0, r0_a[k*BLK +: BLK]} + {1'b0, r0_b[k*BLK +: BLK]};
      w_s1[k] = w_s0[k] + BLK'(1);
      w_p[k]  = &(r0_a[k*BLK +: BLK] ^ r0_b[k*BLK +: BLK]);
    end
  end
  // Speculated carry looks only one segment back; true carry ripples through G/P
  assign w_cs = {r1_g[NSEG-2:0], 1'b0};
  assign w_ca = r1_g[NSEG-1] | (r1_p[NSEG-1] & w_cs[NSEG-1]);
  always_comb begin : resolve
    logic c;
    c    = 1'b0;
    w_ct = '0;
    w_sa = '0;
    w_se = '0;
    for (int k = 0; k < NSEG; k++) begin
      w_ct[k] = c;
      w_sa[k*BLK +: BLK] = w_cs[k] ? r1_s1[k] : r1_s0[k];
      w_se[k*BLK +: BLK] = c ? r1_s1[k] : r1_s0[k];
      c = r1_g[k] | (r1_p[k] & c);
    end
    w_ce = c;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r0_v <= 1'b0; r0_m <= 1'b0; r0_a <= '0; r0_b <= '0;
      r1_v <= 1'b0; r1_m <= 1'b0; r1_s0 <= '0; r1_s1 <= '0; r1_g <= '0; r1_p <= '0;
      r2_v <= 1'b0; r2_m <= 1'b0; r2_sa <= '0; r2_se <= '0; r2_ca <= 1'b0; r2_ce <= 1'b0; r2_es <= '0;
      r_ov <= 1'b0; r_sum <= '0; r_cout <= 1'b0; r_err <= 1'b0; r_es <= '0;
    end else if (w_en) begin
      r0_v  <= in_valid;
      r0_m  <= mode;
      r0_a  <= a;
      r0_b  <= b;
      r1_v  <= r0_v;
      r1_m  <= r0_m;
      r1_s0 <= w_s0;
      r1_s1 <= w_s1;
      r1_g  <= w_g;
      r1_p  <= w_p;
      r2_v  <= r1_v;
      r2_m  <= r1_m;
      r2_sa <= w_sa;
      r2_se <= w_se;
      r2_ca <= w_ca;
      r2_ce <= w_ce;
      r2_es <= w_cs ^ w_ct;
      r_ov   <= r2_v;
      r_sum  <= r2_m ? r2_se : r2_sa;
      r_cout <= r2_m ? r2_ce : r2_ca;
      r_err  <= (|r2_es) | (r2_ca ^ r2_ce);
      r_es   <= r2_es;
    end
  always_ff @(posedge clk)
    if (rst || clr_cnt) r_cnt <= '0;
    else if (r_ov && out_ready && r_err && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
endmodule
